tx_axis_arbiter: RTL and testbench

Frame-level round-robin scheduler that shares one TX MAC AXI-Stream input among NUM_PORTS requesters. It grants one requester at a time, locks the grant for a whole frame (through the tlast beat), then enforces a programmable idle gap before re-arbitrating. The gap gives the MAC time to finish CRC and IFG insertion. It sits directly upstream of the TX MAC's s_axis port.

---
 rtl/tx_axis_arbiter.sv | 146 ++++++++++++++
 tb/tb_tx_axis_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_axis_arbiter.sv
// Frame-level round-robin scheduler in front of the TX MAC s_axis port.
// Locks the grant for a whole frame, then idles GAP_CYCLES before re-arbitrating.
module tx_axis_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_PORTS  = 4,
    parameter int GAP_CYCLES = 3
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_trdy,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_trdy,
    output logic [NUM_PORTS-1:0]            o_grant,
    output logic                            o_busy,
    output logic                            o_frame_done
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_GAP
    } state_t;

    state_t                 r_state;
    logic [PTR_W-1:0]       r_grant_idx;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [CNT_W-1:0]       r_gap_cnt;
    logic [NUM_PORTS-1:0]   r_grant;
    logic                   r_frame_done;

    logic [DATA_WIDTH-1:0]  w_port_data [NUM_PORTS];
    logic [KEEP_WIDTH-1:0]  w_port_keep [NUM_PORTS];
    logic                   w_req_found;
    logic [PTR_W-1:0]       w_req_idx;
    logic [PTR_W-1:0]       w_next_ptr;
    logic                   w_last_hs;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign w_port_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_port_keep[gi] = s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
        end
    endgenerate

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_PORTS) begin
            sum = sum - NUM_PORTS;
        end
        return PTR_W'(sum);
    endfunction

    // Scan offsets from highest to lowest so the port nearest rr_ptr wins.
    always_comb begin
        w_req_found = 1'b0;
        w_req_idx   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (s_axis_tvalid[wrap_add(r_rr_ptr, i)]) begin
                w_req_found = 1'b1;
                w_req_idx   = wrap_add(r_rr_ptr, i);
            end
        end
    end

    assign w_next_ptr = (r_grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : r_grant_idx + 1'b1;

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_trdy   = '0;
        if (r_state == ST_PASS) begin
            m_axis_tdata               = w_port_data[r_grant_idx];
            m_axis_tkeep               = w_port_keep[r_grant_idx];
            m_axis_tvalid              = s_axis_tvalid[r_grant_idx];
            m_axis_tlast               = s_axis_tlast[r_grant_idx];
            s_axis_trdy[r_grant_idx]   = m_axis_trdy;
        end
    end

    assign w_last_hs = m_axis_tvalid & m_axis_trdy & m_axis_tlast;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_grant_idx  <= '0;
            r_rr_ptr     <= '0;
            r_gap_cnt    <= '0;
            r_grant      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_found) begin
                        r_grant_idx <= w_req_idx;
                        r_grant     <= NUM_PORTS'(1) << w_req_idx;
                        r_state     <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    // Grant is held until tlast, even if the requester drops tvalid.
                    if (w_last_hs) begin
                        r_rr_ptr     <= w_next_ptr;
                        r_frame_done <= 1'b1;
                        r_grant      <= '0;
                        if (GAP_CYCLES == 0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_gap_cnt <= CNT_W'(GAP_CYCLES);
                            r_state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt - 1'b1;
                    if (r_gap_cnt <= CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_grant      = r_grant;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Self-checking bench for tx_axis_arbiter: vector table, directed corner cases,
// and randomized traffic against a cycle-count reference model (GAP 3 and GAP 0 instances).
module tb_tx_axis_arbiter;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int NP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*KW-1:0]  s_tkeep;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;
    logic              m_trdy;

    logic [NP-1:0]     s_trdy_a, grant_a, s_trdy_b, grant_b;
    logic [DW-1:0]     m_tdata_a, m_tdata_b;
    logic [KW-1:0]     m_tkeep_a, m_tkeep_b;
    logic              m_tvalid_a, m_tlast_a, busy_a, done_a;
    logic              m_tvalid_b, m_tlast_b, busy_b, done_b;

    tx_axis_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_PORTS(NP), .GAP_CYCLES(3)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_trdy(s_trdy_a),
        .m_axis_tdata(m_tdata_a), .m_axis_tkeep(m_tkeep_a), .m_axis_tvalid(m_tvalid_a),
        .m_axis_tlast(m_tlast_a), .m_axis_trdy(m_trdy),
        .o_grant(grant_a), .o_busy(busy_a), .o_frame_done(done_a)
    );

    tx_axis_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_PORTS(NP), .GAP_CYCLES(0)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_trdy(s_trdy_b),
        .m_axis_tdata(m_tdata_b), .m_axis_tkeep(m_tkeep_b), .m_axis_tvalid(m_tvalid_b),
        .m_axis_tlast(m_tlast_b), .m_axis_trdy(m_trdy),
        .o_grant(grant_b), .o_busy(busy_b), .o_frame_done(done_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_trdy   = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] port_word(input int p);
        return 32'hC0DE_0000 | (32'(p) * 32'h111);
    endfunction

    function automatic logic [3:0] port_keep(input int p);
        return 4'hF >> p;
    endfunction

    task automatic load_fixed_data();
        for (int p = 0; p < NP; p++) begin
            s_tdata[p*DW +: DW] = port_word(p);
            s_tkeep[p*KW +: KW] = port_keep(p);
        end
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       trdy;
        logic [3:0] grant;
        logic       mvalid;
        logic       mlast;
        logic [3:0] strdy;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic t,
                                input logic [3:0] g, input logic mv, input logic ml,
                                input logic [3:0] sr, input logic b, input logic d);
        vec_t r;
        r.valid = v; r.last = l; r.trdy = t; r.grant = g; r.mvalid = mv;
        r.mlast = ml; r.strdy = sr; r.busy = b; r.done = d;
        return r;
    endfunction

    // Reference model state per instance: current owner (-1 none), rr pointer,
    // first cycle number at which arbitration is allowed, pending done pulse.
    int m_cur[2], m_rr[2], m_arb[2], gapv[2];
    bit m_done[2];
    int n;

    task automatic model_check(input int k);
        logic [3:0]  eg, es;
        logic        ev, el, eb;
        logic [31:0] ed;
        logic [3:0]  ek;
        eg = '0; es = '0; ev = 1'b0; el = 1'b0; ed = '0; ek = '0;
        if (m_cur[k] >= 0) begin
            eg[m_cur[k]] = 1'b1;
            es[m_cur[k]] = m_trdy;
            ev = s_tvalid[m_cur[k]];
            el = s_tlast[m_cur[k]];
            ed = s_tdata[m_cur[k]*DW +: DW];
            ek = s_tkeep[m_cur[k]*KW +: KW];
        end
        eb = (m_cur[k] >= 0) || (n < m_arb[k]);
        check($sformatf("rnd%0d_c%0d_grant", k, n), k == 0 ? grant_a : grant_b, eg);
        check($sformatf("rnd%0d_c%0d_strdy", k, n), k == 0 ? s_trdy_a : s_trdy_b, es);
        check($sformatf("rnd%0d_c%0d_mvalid", k, n), k == 0 ? m_tvalid_a : m_tvalid_b, ev);
        check($sformatf("rnd%0d_c%0d_mlast", k, n), k == 0 ? m_tlast_a : m_tlast_b, el);
        check($sformatf("rnd%0d_c%0d_mdata", k, n), k == 0 ? m_tdata_a : m_tdata_b, ed);
        check($sformatf("rnd%0d_c%0d_mkeep", k, n), k == 0 ? m_tkeep_a : m_tkeep_b, ek);
        check($sformatf("rnd%0d_c%0d_busy", k, n), k == 0 ? busy_a : busy_b, eb);
        check($sformatf("rnd%0d_c%0d_done", k, n), k == 0 ? done_a : done_b, m_done[k]);
    endtask

    task automatic model_edge(input int k, input bit rst);
        int  p2;
        bit  found;
        if (rst) begin
            m_cur[k] = -1; m_rr[k] = 0; m_arb[k] = n + 1; m_done[k] = 1'b0;
        end else begin
            m_done[k] = 1'b0;
            if (m_cur[k] >= 0) begin
                if (s_tvalid[m_cur[k]] && m_trdy && s_tlast[m_cur[k]]) begin
                    if (k == 0) $display("frame end: port %0d cycle %0d", m_cur[k], n);
                    m_rr[k]   = (m_cur[k] + 1) % NP;
                    m_cur[k]  = -1;
                    m_arb[k]  = n + gapv[k] + 1;
                    m_done[k] = 1'b1;
                end
            end else if (n >= m_arb[k] && s_tvalid != '0) begin
                found = 1'b0;
                for (int i = 0; i < NP; i++) begin
                    p2 = (m_rr[k] + i) % NP;
                    if (!found && s_tvalid[p2]) begin
                        m_cur[k] = p2;
                        found = 1'b1;
                    end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    logic [32:0] rxq[$];
    int b, stall, beats, gidx;
    bit rst_r;

    initial begin
        s_tdata = '0;
        s_tkeep = '0;
        load_fixed_data();
        do_reset();

        // valid, last, trdy | grant, mvalid, mlast, strdy, busy, done
        tbl.push_back(mk(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(4'b0100, 4'b0100, 1, 4'b0000, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(4'b0100, 4'b0100, 1, 4'b0100, 1, 1, 4'b0100, 1, 0));
        tbl.push_back(mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 1, 1));
        tbl.push_back(mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(4'b1001, 4'b1000, 0, 4'b1000, 1, 1, 4'b0000, 1, 0));
        tbl.push_back(mk(4'b1001, 4'b1000, 1, 4'b1000, 1, 1, 4'b1000, 1, 0));
        tbl.push_back(mk(4'b0011, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 1, 1));
        tbl.push_back(mk(4'b0011, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(4'b0011, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(4'b0011, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(4'b0010, 4'b0000, 1, 4'b0001, 0, 0, 4'b0001, 1, 0));
        tbl.push_back(mk(4'b0011, 4'b0001, 1, 4'b0001, 1, 1, 4'b0001, 1, 0));
        tbl.push_back(mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 1, 1));
        tbl.push_back(mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(4'b1001, 4'b1000, 1, 4'b1000, 1, 1, 4'b1000, 1, 0));
        tbl.push_back(mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 1, 1));
        tbl.push_back(mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(4'b1001, 4'b0001, 1, 4'b0001, 1, 1, 4'b0001, 1, 0));
        tbl.push_back(mk(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 1, 1));

        foreach (tbl[r]) begin
            s_tvalid = tbl[r].valid;
            s_tlast  = tbl[r].last;
            m_trdy   = tbl[r].trdy;
            #2;
            gidx = -1;
            for (int p = 0; p < NP; p++) if (tbl[r].grant[p]) gidx = p;
            check($sformatf("row%0d_grant", r), grant_a, tbl[r].grant);
            check($sformatf("row%0d_mvalid", r), m_tvalid_a, tbl[r].mvalid);
            check($sformatf("row%0d_mlast", r), m_tlast_a, tbl[r].mlast);
            check($sformatf("row%0d_strdy", r), s_trdy_a, tbl[r].strdy);
            check($sformatf("row%0d_busy", r), busy_a, tbl[r].busy);
            check($sformatf("row%0d_done", r), done_a, tbl[r].done);
            check($sformatf("row%0d_mdata", r), m_tdata_a, gidx >= 0 ? port_word(gidx) : 32'h0);
            check($sformatf("row%0d_mkeep", r), m_tkeep_a, gidx >= 0 ? port_keep(gidx) : 4'h0);
            $display("vector %0d: grant=%b mvalid=%b busy=%b done=%b", r, grant_a, m_tvalid_a, busy_a, done_a);
            step();
        end

        // Backpressure: port 1 sends 6 beats, trdy low for 5 cycles after beat 2.
        do_reset();
        load_fixed_data();
        s_tvalid = 4'b0010; s_tlast = '0; m_trdy = 1'b1;
        s_tdata[DW +: DW] = 32'hB000_0001;
        #2;
        check("bp_idle_grant", grant_a, 4'b0000);
        step();
        s_tvalid = 4'b1011;
        b = 1; stall = 0;
        rxq.delete();
        for (int c = 0; c < 20 && b <= 6; c++) begin
            m_trdy = !(b == 3 && stall < 5);
            s_tdata[DW +: DW] = 32'hB000_0000 + b;
            s_tlast = (b == 6) ? 4'b0010 : 4'b0000;
            #2;
            check($sformatf("bp_c%0d_grant", c), grant_a, 4'b0010);
            check($sformatf("bp_c%0d_mdata", c), m_tdata_a, 32'hB000_0000 + b);
            check($sformatf("bp_c%0d_strdy", c), s_trdy_a, {2'b00, m_trdy, 1'b0});
            if (m_tvalid_a && m_trdy) begin
                rxq.push_back({m_tlast_a, m_tdata_a});
                b++;
            end else begin
                stall++;
            end
            step();
        end
        check("bp_stall_cycles", stall, 5);
        check("bp_beat_count", rxq.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < rxq.size())
                check($sformatf("bp_beat%0d", i + 1), rxq[i], {(i == 5), 32'hB000_0001 + 32'(i)});
        end
        $display("backpressure frame: %0d beats received", rxq.size());
        s_tvalid = '0; s_tlast = '0;
        #2;
        check("bp_done", done_a, 1'b1);
        repeat (3) step();

        // Port 0 single-beat frame moves rr_ptr to 1.
        s_tvalid = 4'b0001; s_tlast = 4'b0001; m_trdy = 1'b1;
        #2;
        check("p0_idle_busy", busy_a, 1'b0);
        step();
        #2;
        check("p0_grant", grant_a, 4'b0001);
        check("p0_mlast", m_tlast_a, 1'b1);
        step();
        s_tvalid = '0; s_tlast = '0;
        #2;
        check("p0_done", done_a, 1'b1);
        repeat (3) step();

        // Port 1 5-beat frame, reset on beat 3.
        s_tvalid = 4'b0010; s_tlast = '0; m_trdy = 1'b1;
        #2;
        step();
        for (int bb = 1; bb <= 3; bb++) begin
            s_tdata[DW +: DW] = 32'hB100_0000 + bb;
            if (bb == 3) rst_n = 1'b0;
            #2;
            check($sformatf("mr_beat%0d_grant", bb), grant_a, 4'b0010);
            step();
        end
        rst_n = 1'b1;
        s_tvalid = 4'b0011;
        #2;
        check("mr_grant_zero", grant_a, 4'b0000);
        check("mr_mvalid_zero", m_tvalid_a, 1'b0);
        check("mr_mlast_zero", m_tlast_a, 1'b0);
        check("mr_strdy_zero", s_trdy_a, 4'b0000);
        check("mr_mdata_zero", m_tdata_a, 32'h0);
        check("mr_busy_zero", busy_a, 1'b0);
        check("mr_done_zero", done_a, 1'b0);
        step();
        #2;
        check("mr_regrant_port0", grant_a, 4'b0001);
        check("mr_no_done", done_a, 1'b0);
        step();

        // GAP_CYCLES=0 instance: port 2 back-to-back single-beat frames.
        do_reset();
        s_tvalid = 4'b0100; s_tlast = 4'b0100; m_trdy = 1'b1;
        beats = 0;
        for (int k = 0; k < 8; k++) begin
            s_tdata[2*DW +: DW] = 32'h2200_0000 + k;
            #2;
            check($sformatf("g0_c%0d_grant", k), grant_b, (k % 2 == 1) ? 4'b0100 : 4'b0000);
            check($sformatf("g0_c%0d_mvalid", k), m_tvalid_b, (k % 2 == 1));
            check($sformatf("g0_c%0d_busy", k), busy_b, (k % 2 == 1));
            check($sformatf("g0_c%0d_done", k), done_b, (k >= 2 && k % 2 == 0));
            if (m_tvalid_b && m_trdy) beats++;
            step();
        end
        check("g0_beats_in_8", beats, 4);

        // Randomized traffic on both instances against the reference model.
        do_reset();
        gapv[0] = 3; gapv[1] = 0;
        for (int k = 0; k < 2; k++) begin
            m_cur[k] = -1; m_rr[k] = 0; m_arb[k] = 0; m_done[k] = 1'b0;
        end
        n = 0;
        for (int c = 0; c < 800; c++) begin
            rst_r = ($urandom_range(0, 99) < 2);
            rst_n = !rst_r;
            for (int p = 0; p < NP; p++) begin
                s_tvalid[p] = ($urandom_range(0, 99) < 60);
                s_tlast[p]  = ($urandom_range(0, 99) < 35);
                s_tdata[p*DW +: DW] = $urandom;
                s_tkeep[p*KW +: KW] = 4'($urandom_range(0, 15));
            end
            m_trdy = ($urandom_range(0, 99) < 70);
            #2;
            model_check(0);
            model_check(1);
            model_edge(0, rst_r);
            model_edge(1, rst_r);
            step();
            n++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
